// File: rtl/miriscv_data_arbiter.sv
// Two-master arbiter onto one single-ported RAM data port, one outstanding transaction at a time.
// Grant is combinational in the request cycle; response is forwarded the cycle rvalid arrives, or as an error after TIMEOUT_CYCLES.
module miriscv_data_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_WAIT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sel;
    logic          r_owner;
    logic          r_last_grant;
    logic [TW-1:0] r_tmo_cnt;

    logic w_winner;
    logic w_cur_sel;
    logic w_cur_req;
    logic w_gnt;
    logic w_rsp_ok;
    logic w_rsp_tmo;
    logic w_rsp;

    always_comb begin
        w_winner = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            w_winner = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
        end
    end

    // HOLD keeps the earlier choice so a late request from the other master cannot steal the slot.
    always_comb begin
        w_cur_sel = (r_state == ST_HOLD) ? r_sel : w_winner;
        case (r_state)
            ST_IDLE: w_cur_req = m0_req_i | m1_req_i;
            ST_HOLD: w_cur_req = r_sel ? m1_req_i : m0_req_i;
            default: w_cur_req = 1'b0;
        endcase
    end

    assign w_gnt     = w_cur_req & s_gnt_i;
    assign w_rsp_ok  = (r_state == ST_WAIT) & s_rvalid_i;
    assign w_rsp_tmo = (r_state == ST_WAIT) & ~s_rvalid_i & (r_tmo_cnt == TMO_LAST);
    assign w_rsp     = w_rsp_ok | w_rsp_tmo;

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_cur_req) w_state_nxt = s_gnt_i ? ST_WAIT : ST_HOLD;
            ST_HOLD: begin
                if (!w_cur_req)  w_state_nxt = ST_IDLE;
                else if (s_gnt_i) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: if (w_rsp) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            r_sel        <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_tmo_cnt    <= '0;
        end else begin
            if (w_gnt) begin
                r_owner      <= w_cur_sel;
                r_last_grant <= w_cur_sel;
                r_tmo_cnt    <= '0;
            end
            if (r_state == ST_IDLE && w_cur_req && !s_gnt_i) begin
                r_sel <= w_winner;
            end
            if (r_state == ST_WAIT && !w_rsp) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end
    end

    always_comb begin
        s_req_o     = w_cur_req;
        s_we_o      = w_cur_req & (w_cur_sel ? m1_we_i : m0_we_i);
        s_be_o      = {4{w_cur_req}} & (w_cur_sel ? m1_be_i : m0_be_i);
        s_addr_o    = {32{w_cur_req}} & (w_cur_sel ? m1_addr_i : m0_addr_i);
        s_wdata_o   = {32{w_cur_req}} & (w_cur_sel ? m1_wdata_i : m0_wdata_i);
        m0_gnt_o    = w_gnt & ~w_cur_sel;
        m1_gnt_o    = w_gnt & w_cur_sel;
        m0_rvalid_o = w_rsp & ~r_owner;
        m1_rvalid_o = w_rsp & r_owner;
        m0_err_o    = w_rsp_tmo & ~r_owner;
        m1_err_o    = w_rsp_tmo & r_owner;
        m0_rdata_o  = (w_rsp_ok & ~r_owner) ? s_rdata_i : 32'h0;
        m1_rdata_o  = (w_rsp_ok & r_owner) ? s_rdata_i : 32'h0;
        if (rst_n_i) begin
            s_req_o     = 1'b0;
            s_we_o      = 1'b0;
            s_be_o      = 4'h0;
            s_addr_o    = 32'h0;
            s_wdata_o   = 32'h0;
            m0_gnt_o    = 1'b0;
            m1_gnt_o    = 1'b0;
            m0_rvalid_o = 1'b0;
            m1_rvalid_o = 1'b0;
            m0_err_o    = 1'b0;
            m1_err_o    = 1'b0;
            m0_rdata_o  = 32'h0;
            m1_rdata_o  = 32'h0;
        end
    end
endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Bench for miriscv_data_arbiter: round-robin instance with a RAM model and scoreboard, plus a fixed-priority instance.
module tb_miriscv_data_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: round-robin, with a RAM model whose rvalid delay is programmable.
    logic        a_m0_req = 0, a_m0_we = 0, a_m1_req = 0, a_m1_we = 0;
    logic [3:0]  a_m0_be = 4'hF, a_m1_be = 4'hF;
    logic [31:0] a_m0_addr = 0, a_m0_wdata = 0, a_m1_addr = 0, a_m1_wdata = 0;
    logic        a_m0_gnt, a_m0_rvalid, a_m0_err, a_m1_gnt, a_m1_rvalid, a_m1_err;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_s_req, a_s_we, a_s_gnt, a_s_rvalid;
    logic [3:0]  a_s_be;
    logic [31:0] a_s_addr, a_s_wdata, a_s_rdata;

    // Instance B: fixed priority, RAM always grants and echoes the address as read data.
    logic        b_m0_req = 0, b_m1_req = 0;
    logic [31:0] b_m0_addr = 32'hA0, b_m1_addr = 32'hB0;
    logic        b_m0_gnt, b_m0_rvalid, b_m0_err, b_m1_gnt, b_m1_rvalid, b_m1_err;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_s_req, b_s_we, b_s_rvalid;
    logic [3:0]  b_s_be;
    logic [31:0] b_s_addr, b_s_wdata, b_s_rdata;

    miriscv_data_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(16)) u_a (
        .clk_i(clk), .rst_n_i(rst),
        .m0_req_i(a_m0_req), .m0_we_i(a_m0_we), .m0_be_i(a_m0_be), .m0_addr_i(a_m0_addr), .m0_wdata_i(a_m0_wdata),
        .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid), .m0_rdata_o(a_m0_rdata), .m0_err_o(a_m0_err),
        .m1_req_i(a_m1_req), .m1_we_i(a_m1_we), .m1_be_i(a_m1_be), .m1_addr_i(a_m1_addr), .m1_wdata_i(a_m1_wdata),
        .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid), .m1_rdata_o(a_m1_rdata), .m1_err_o(a_m1_err),
        .s_req_o(a_s_req), .s_we_o(a_s_we), .s_be_o(a_s_be), .s_addr_o(a_s_addr), .s_wdata_o(a_s_wdata),
        .s_gnt_i(a_s_gnt), .s_rvalid_i(a_s_rvalid), .s_rdata_i(a_s_rdata));

    miriscv_data_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(16)) u_b (
        .clk_i(clk), .rst_n_i(rst),
        .m0_req_i(b_m0_req), .m0_we_i(1'b0), .m0_be_i(4'hF), .m0_addr_i(b_m0_addr), .m0_wdata_i(32'h0),
        .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid), .m0_rdata_o(b_m0_rdata), .m0_err_o(b_m0_err),
        .m1_req_i(b_m1_req), .m1_we_i(1'b0), .m1_be_i(4'hF), .m1_addr_i(b_m1_addr), .m1_wdata_i(32'h0),
        .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid), .m1_rdata_o(b_m1_rdata), .m1_err_o(b_m1_err),
        .s_req_o(b_s_req), .s_we_o(b_s_we), .s_be_o(b_s_be), .s_addr_o(b_s_addr), .s_wdata_o(b_s_wdata),
        .s_gnt_i(b_s_req), .s_rvalid_i(b_s_rvalid), .s_rdata_i(b_s_rdata));

    // RAM model for A
    logic [31:0] mem [0:63];
    bit          mem_init = 1'b1;
    bit          gnt_en = 1'b0;
    int          rv_delay = 1;
    bit          rv_q = 1'b0, pend = 1'b0;
    int          pcnt = 0;
    bit   [31:0] rd_q = 32'h0;
    int          cyc = 0;

    assign a_s_gnt    = gnt_en & a_s_req;
    assign a_s_rvalid = rv_q;
    assign a_s_rdata  = rd_q;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rv_q <= 1'b0;
        if (mem_init) begin
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'hFFFFFFFF;
        end
        if (pend) begin
            if (pcnt == 1) begin rv_q <= 1'b1; pend <= 1'b0; end
            else pcnt <= pcnt - 1;
        end
        if (a_s_req && a_s_gnt) begin
            rd_q <= mem[a_s_addr[7:2]];
            if (a_s_we)
                for (int b = 0; b < 4; b++)
                    if (a_s_be[b]) mem[a_s_addr[7:2]][8*b +: 8] <= a_s_wdata[8*b +: 8];
            if (rv_delay == 1) rv_q <= 1'b1;
            else if (rv_delay > 1) begin pend <= 1'b1; pcnt <= rv_delay - 1; end
        end
    end

    bit          b_rv_q = 1'b0;
    bit   [31:0] b_rd_q = 32'h0;
    assign b_s_rvalid = b_rv_q;
    assign b_s_rdata  = b_rd_q;
    always @(posedge clk) begin
        b_rv_q <= b_s_req;
        if (b_s_req) b_rd_q <= b_s_addr;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: expectations pushed when a transaction is issued, popped on rvalid.
    typedef struct {bit m; logic [31:0] rdata; bit err; bit chk_dat;} exp_t;
    exp_t q[$];
    int   resp_cyc = 0;

    always @(negedge clk) begin
        if (a_m0_rvalid || a_m1_rvalid) begin
            if (q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_rvalid: got m0=%b m1=%b expected none", a_m0_rvalid, a_m1_rvalid);
            end else begin
                exp_t e;
                e = q.pop_front();
                resp_cyc = cyc;
                chk("resp_both", {31'h0, a_m0_rvalid & a_m1_rvalid}, 32'h0);
                chk("resp_master", {31'h0, a_m1_rvalid}, {31'h0, e.m});
                chk("resp_err", {31'h0, e.m ? a_m1_err : a_m0_err}, {31'h0, e.err});
                if (e.chk_dat) chk("resp_rdata", e.m ? a_m1_rdata : a_m0_rdata, e.rdata);
                chk("resp_other_zero", e.m ? (a_m0_rdata | {30'h0, a_m0_rvalid, a_m0_err})
                                           : (a_m1_rdata | {30'h0, a_m1_rvalid, a_m1_err}), 32'h0);
            end
        end
    end

    task automatic wait_drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk({nm, "_drain"}, 32'(q.size()), 32'h0);
        q.delete();
    endtask

    task automatic do_txn(input string nm, input bit m, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] erd, input bit eerr, input bit echk, input int lat);
        bit got = 1'b0;
        int g = 0;
        if (m) begin a_m1_we = we; a_m1_be = be; a_m1_addr = addr; a_m1_wdata = wdata; a_m1_req = 1'b1; end
        else   begin a_m0_we = we; a_m0_be = be; a_m0_addr = addr; a_m0_wdata = wdata; a_m0_req = 1'b1; end
        q.push_back('{m: m, rdata: erd, err: eerr, chk_dat: echk});
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m ? a_m1_gnt : a_m0_gnt) begin
                got = 1'b1;
                g = cyc;
                chk({nm, "_other_gnt"}, {31'h0, m ? a_m0_gnt : a_m1_gnt}, 32'h0);
            end
        end
        chk({nm, "_gnt"}, {31'h0, got}, 32'h1);
        @(posedge clk); #1;
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        if (!got) q.delete();
        wait_drain(nm);
        if (got) chk({nm, "_lat"}, 32'(resp_cyc - g), 32'(lat));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic m0_req, m1_req, m0_we, m1_we;
        logic [3:0] m0_be, m1_be;
        logic [31:0] m0_addr, m1_addr;
        logic exp_req, chk_dat, exp_we;
        logic [3:0] exp_be;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vt [4];

    initial begin
        logic [7:0] p_g0, p_g1, p_v0, p_v1;

        // Reset with requests asserted: every output must stay low.
        a_m0_req = 1'b1; a_m1_req = 1'b1; b_m0_req = 1'b1; b_m1_req = 1'b1;
        @(negedge clk);
        chk("rst_s_req", {31'h0, a_s_req}, 32'h0);
        chk("rst_gnt", {30'h0, a_m0_gnt, a_m1_gnt}, 32'h0);
        chk("rst_b_outs", {29'h0, b_s_req, b_m0_gnt, b_m1_gnt}, 32'h0);
        chk("rst_s_addr", a_s_addr, 32'h0);
        @(posedge clk); #1;
        a_m0_req = 1'b0; a_m1_req = 1'b0; b_m0_req = 1'b0; b_m1_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        chk("idle_s_req", {31'h0, a_s_req}, 32'h0);
        chk("idle_rvalid", {30'h0, a_m0_rvalid, a_m1_rvalid}, 32'h0);
        @(posedge clk); #1;

        // Request muxing in IDLE, with RAM grant withheld; tie goes to m0 after reset.
        vt[0] = '{0, 0, 0, 0, 4'h0, 4'h0, 32'h0,   32'h0,   0, 0, 0, 4'h0, 32'h0};
        vt[1] = '{1, 0, 1, 0, 4'hF, 4'h3, 32'h100, 32'h200, 1, 1, 1, 4'hF, 32'h100};
        vt[2] = '{0, 1, 1, 0, 4'hF, 4'h3, 32'h100, 32'h200, 1, 1, 0, 4'h3, 32'h200};
        vt[3] = '{1, 1, 1, 0, 4'hF, 4'h3, 32'h100, 32'h200, 1, 1, 1, 4'hF, 32'h100};
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_m0_req = vt[i].m0_req; a_m1_req = vt[i].m1_req; a_m0_we = vt[i].m0_we; a_m1_we = vt[i].m1_we;
            a_m0_be = vt[i].m0_be; a_m1_be = vt[i].m1_be; a_m0_addr = vt[i].m0_addr; a_m1_addr = vt[i].m1_addr;
            @(negedge clk);
            chk($sformatf("vec%0d_s_req", i), {31'h0, a_s_req}, {31'h0, vt[i].exp_req});
            chk($sformatf("vec%0d_gnt", i), {30'h0, a_m0_gnt, a_m1_gnt}, 32'h0);
            if (vt[i].chk_dat) begin
                chk($sformatf("vec%0d_s_addr", i), a_s_addr, vt[i].exp_addr);
                chk($sformatf("vec%0d_s_be_we", i), {27'h0, a_s_be, a_s_we}, {27'h0, vt[i].exp_be, vt[i].exp_we});
            end
            @(posedge clk); #1;
            a_m0_req = 1'b0; a_m1_req = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_withdraw", i), {31'h0, a_s_req}, 32'h0);
            @(posedge clk); #1;
        end
        gnt_en = 1'b1; rv_delay = 1;

        do_txn("rd_m0", 1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1);
        do_txn("wr_m1", 1'b1, 1'b1, 4'h3, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0, 1);
        do_txn("rd_m1", 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 32'hFFFF5678, 1'b0, 1'b1, 1);

        // Round-robin contention from a fresh reset.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_m0_we = 0; a_m1_we = 0; a_m0_be = 4'hF; a_m1_be = 4'hF; a_m0_addr = 32'h10; a_m1_addr = 32'h20;
        q.push_back('{m: 0, rdata: 32'hDEADBEEF, err: 0, chk_dat: 1});
        q.push_back('{m: 1, rdata: 32'hFFFF5678, err: 0, chk_dat: 1});
        q.push_back('{m: 0, rdata: 32'hDEADBEEF, err: 0, chk_dat: 1});
        q.push_back('{m: 1, rdata: 32'hFFFF5678, err: 0, chk_dat: 1});
        a_m0_req = 1'b1; a_m1_req = 1'b1;
        p_g0 = 8'b0001_0001; p_g1 = 8'b0100_0100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rr_c%0d_gnt", i), {30'h0, a_m0_gnt, a_m1_gnt}, {30'h0, p_g0[i], p_g1[i]});
            @(posedge clk); #1;
        end
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        wait_drain("rr");
        @(posedge clk); #1;

        // Fixed priority: m0 wins every arbitration until it drops its request.
        b_m0_req = 1'b1; b_m1_req = 1'b1;
        p_g0 = 8'b0001_0101; p_g1 = 8'b0100_0000; p_v0 = 8'b0010_1010; p_v1 = 8'b1000_0000;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) b_m0_req = 1'b0;
            @(negedge clk);
            chk($sformatf("fp_c%0d_gnt", i), {30'h0, b_m0_gnt, b_m1_gnt}, {30'h0, p_g0[i], p_g1[i]});
            chk($sformatf("fp_c%0d_rvalid", i), {30'h0, b_m0_rvalid, b_m1_rvalid}, {30'h0, p_v0[i], p_v1[i]});
            if (p_v0[i]) chk($sformatf("fp_c%0d_rdata0", i), b_m0_rdata, 32'hA0);
            if (p_v1[i]) chk($sformatf("fp_c%0d_rdata1", i), b_m1_rdata, 32'hB0);
            @(posedge clk); #1;
        end
        b_m1_req = 1'b0;

        // Timeout with no rvalid, then rvalid landing exactly on the terminal cycle.
        rv_delay = 0;
        do_txn("tmo", 1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, 16);
        rv_delay = 16;
        do_txn("tmo_edge", 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 16);
        rv_delay = 1;

        // HOLD: m1 selected while RAM stalls; m0 arriving later must not take over.
        gnt_en = 1'b0;
        a_m1_addr = 32'h20; a_m1_req = 1'b1;
        @(posedge clk); #1;
        a_m0_addr = 32'h10; a_m0_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_s_addr", i), a_s_addr, 32'h20);
            chk($sformatf("hold%0d_gnt", i), {30'h0, a_m0_gnt, a_m1_gnt}, 32'h0);
            @(posedge clk); #1;
        end
        gnt_en = 1'b1;
        q.push_back('{m: 1, rdata: 32'hFFFF5678, err: 0, chk_dat: 1});
        @(negedge clk);
        chk("hold_release_gnt", {30'h0, a_m0_gnt, a_m1_gnt}, 32'h1);
        @(posedge clk); #1;
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        wait_drain("hold");
        @(posedge clk); #1;

        // Reset during WAIT: the late rvalid must be dropped.
        rv_delay = 3;
        a_m0_addr = 32'h10; a_m0_req = 1'b1;
        @(negedge clk);
        chk("rstw_gnt", {31'h0, a_m0_gnt}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; a_m1_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rstw%0d_outs", i), {28'h0, a_s_req, a_m0_gnt, a_m1_gnt, a_m0_rvalid | a_m1_rvalid}, 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0; a_m0_req = 1'b0; a_m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rstw_stray%0d", i), {30'h0, a_m0_rvalid, a_m1_rvalid}, 32'h0);
            @(posedge clk); #1;
        end
        rv_delay = 1;
        do_txn("post_rst", 1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/miriscv_data_arbiter.md
Name: miriscv_data_arbiter

Overview:
- Two-master arbiter that shares the single-ported RAM data interface (req/gnt/rvalid, byte enables) between master 0 (core LSU) and master 1 (auxiliary: loader/DMA/debug).
- Allows one outstanding transaction at a time, with round-robin or fixed priority.
- Returns read data to the owning master and raises an error response if rvalid never arrives.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = master 0 always wins.
- TIMEOUT_CYCLES, 16: cycles in WAIT without s_rvalid before an error response (must be >= 2).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous reset, active-high
- mN_req_i  in  1  request, N = 0,1 (the same set of ports exists for each master)
- mN_we_i  in  1  write enable
- mN_be_i  in  4  byte enables
- mN_addr_i  in  32  byte address
- mN_wdata_i  in  32  write data
- mN_gnt_o  out  1  request accepted
- mN_rvalid_o  out  1  response valid
- mN_rdata_o  out  32  read data
- mN_err_o  out  1  timeout error, qualified by mN_rvalid_o
- s_req_o  out  1  to RAM data_req
- s_we_o  out  1  to RAM data_we
- s_be_o  out  4  to RAM data_be
- s_addr_o  out  32  to RAM data_addr
- s_wdata_o  out  32  to RAM data_wdata
- s_gnt_i  in  1  from RAM data_gnt
- s_rvalid_i  in  1  from RAM data_rvalid
- s_rdata_i  in  32  from RAM data_rdata

Behaviour:
- Registers: state (IDLE, HOLD, WAIT), sel (1b), owner (1b), last_grant (1b), tmo_cnt ($clog2(TIMEOUT_CYCLES+1) bits).
- Reset (rst_n_i=1 at clk edge): state=IDLE, sel=0, owner=0, last_grant=1 (so m0 wins the first tie), tmo_cnt=0.
- While rst_n_i=1, all outputs are forced to 0, overriding the combinational paths.
- Winner (combinational, evaluated in IDLE):
  - only one request → that master wins;
  - both requesting, FIXED_PRIO=1 → m0;
  - both requesting, FIXED_PRIO=0 → !last_grant.
- IDLE:
  - any mN_req_i → s_req_o=1, s_we/be/addr/wdata muxed from the winner, combinational, same cycle;
  - if s_gnt_i → winner's mN_gnt_o=1 this cycle, owner<=winner, last_grant<=winner, tmo_cnt<=0, next WAIT;
  - no s_gnt_i → sel<=winner, next HOLD.
- HOLD (selection locked, no re-arbitration):
  - drive s_* from sel;
  - if msel_req_i=0 (request withdrawn) → s_req_o=0, next IDLE;
  - else if s_gnt_i → msel_gnt_o=1, owner<=sel, last_grant<=sel, tmo_cnt<=0, next WAIT.
- WAIT:
  - s_req_o=0, all mN_gnt_o=0;
  - s_rvalid_i → mowner_rvalid_o=1, mowner_rdata_o=s_rdata_i, err=0, same cycle (no added latency), next IDLE;
  - else tmo_cnt++; when tmo_cnt==TIMEOUT_CYCLES-1 without rvalid → mowner_rvalid_o=1, mowner_err_o=1, rdata=0, next IDLE.
- Writes also receive an rvalid response; rdata for writes is passed through and is don't-care.
- Non-owner rvalid/err are always 0. Each mN_rdata_o is 0 when its rvalid is 0.
- Simultaneous s_rvalid_i and timeout terminal count: rvalid wins, err=0.
- s_rvalid_i in IDLE/HOLD (stray) is ignored and never forwarded.
- Since s_req_o is low in WAIT, the RAM never sees back-to-back requests.
- Throughput: at most one transaction per 2 cycles. Latency against the RAM: gnt in the request cycle, rvalid 1 cycle later.
- Reset mid-WAIT: the transaction is dropped and no response is delivered. A post-reset s_rvalid_i is ignored.
- Masters hold all request fields stable from req until gnt; the block does not check this.

Test Plan:
- Single read: m0 req, addr=0x10, RAM word4=0xDEADBEEF → m0_gnt same cycle, m0_rvalid=1 and rdata=0xDEADBEEF next cycle; m1 outputs all 0.
- Write then read, be=4'b0011: m1 writes wdata=0x12345678 to 0x20 over word 0xFFFFFFFF → m1 reads 0xFFFF5678; gnt/rvalid only on m1.
- Contention, FIXED_PRIO=0: both request continuously → grants in order m0, m1, m0, m1, one grant every 2 cycles; rdata is routed to the matching master.
- Contention, FIXED_PRIO=1: both request → m0 granted on every transaction; m1 granted only once m0_req drops.
- Timeout: RAM model withholds rvalid after gnt, TIMEOUT_CYCLES=16 → owner rvalid=1, err=1, rdata=0 on the 16th WAIT cycle; then IDLE. Also cover rvalid arriving on the terminal cycle → err=0.
- HOLD and reset:
  - s_gnt_i held 0 with m1 selected, then m0 requests → no switch, m1 granted when s_gnt_i rises;
  - reset asserted in WAIT, then stray s_rvalid_i → no rvalid on either master; all outputs 0 during reset.
